// File: rtl/alu_pkg.sv
// Shared definitions for the two-port ALU sharing block: opcodes, FSM states
// and the supported-opcode check.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0011;
  localparam logic [OP_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [OP_W-1:0] ALU_ADD = 4'b0101;
  localparam logic [OP_W-1:0] ALU_EQ  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_NE  = 4'b1001;
  localparam logic [OP_W-1:0] ALU_LT  = 4'b1010;
  localparam logic [OP_W-1:0] ALU_GE  = 4'b1011;
  localparam logic [OP_W-1:0] ALU_SRL = 4'b1100;
  localparam logic [OP_W-1:0] ALU_SLL = 4'b1101;
  localparam logic [OP_W-1:0] ALU_SLT = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_supported_op(input logic [OP_W-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      ALU_AND, ALU_OR, ALU_SUB, ALU_XOR, ALU_ADD,
      ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_SRL, ALU_SLL, ALU_SLT: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of both requester channels plus the shared-ALU drive/return lines.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both
// high; the sender holds valid and its payload stable until that edge, and valid
// never waits on ready.
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);

    logic                     req0_valid;
    logic                     req0_ready;
    logic [OPCODE_LENGTH-1:0] req0_op;
    logic [DATA_WIDTH-1:0]    req0_a;
    logic [DATA_WIDTH-1:0]    req0_b;

    logic                     req1_valid;
    logic                     req1_ready;
    logic [OPCODE_LENGTH-1:0] req1_op;
    logic [DATA_WIDTH-1:0]    req1_a;
    logic [DATA_WIDTH-1:0]    req1_b;

    logic                     rsp0_valid;
    logic                     rsp0_ready;
    logic [DATA_WIDTH-1:0]    rsp0_result;
    logic                     rsp0_err;

    logic                     rsp1_valid;
    logic                     rsp1_ready;
    logic [DATA_WIDTH-1:0]    rsp1_result;
    logic                     rsp1_err;

    logic [OPCODE_LENGTH-1:0] alu_operation;
    logic [DATA_WIDTH-1:0]    alu_srca;
    logic [DATA_WIDTH-1:0]    alu_srcb;
    logic [DATA_WIDTH-1:0]    alu_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_result,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_err,
        output rsp1_valid, rsp1_result, rsp1_err,
        output alu_operation, alu_srca, alu_srcb
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_result,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_err,
        input  rsp1_valid, rsp1_result, rsp1_err,
        input  alu_operation, alu_srca, alu_srcb
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, and on contention the port
// that did not win last time is chosen.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt
);

    assign gnt_valid = valid0 | valid1;
    assign gnt       = (valid0 && valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between two requesters, one
// operation in flight, with a registered response held until accepted.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus,
    output state_t              dbg_state
);

    state_t                   state_q, state_d;
    logic                     last_grant_q, last_grant_d;
    logic                     owner_q, owner_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic [DATA_WIDTH-1:0]    a_q, a_d;
    logic [DATA_WIDTH-1:0]    b_q, b_d;
    logic [DATA_WIDTH-1:0]    res0_q, res0_d, res1_q, res1_d;
    logic                     err0_q, err0_d, err1_q, err1_d;
    logic                     vld0_q, vld0_d, vld1_q, vld1_d;

    logic                     gnt_valid;
    logic                     gnt;
    logic                     arb_en;
    logic                     exec_err;
    logic [DATA_WIDTH-1:0]    exec_result;
    logic                     owner_rsp_ready;

    rr_arbiter2 u_arb (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt        (gnt)
    );

    // Commands are only offered in IDLE and never while reset is asserted.
    assign arb_en         = (state_q == IDLE) && !reset;
    assign bus.req0_ready = arb_en && gnt_valid && !gnt;
    assign bus.req1_ready = arb_en && gnt_valid && gnt;

    assign exec_err        = !is_supported_op(op_q);
    assign exec_result     = exec_err ? '0 : bus.alu_result;
    assign owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res0_d       = res0_q;
        res1_d       = res1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        vld0_d       = vld0_q;
        vld1_d       = vld1_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    op_d         = gnt ? bus.req1_op : bus.req0_op;
                    a_d          = gnt ? bus.req1_a  : bus.req0_a;
                    b_d          = gnt ? bus.req1_b  : bus.req0_b;
                    owner_d      = gnt;
                    last_grant_d = gnt;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
                if (owner_q) begin
                    res1_d = exec_result;
                    err1_d = exec_err;
                    vld1_d = 1'b1;
                end else begin
                    res0_d = exec_result;
                    err0_d = exec_err;
                    vld0_d = 1'b1;
                end
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    vld0_d  = 1'b0;
                    vld1_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset discards any in-flight operation and clears every visible output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res0_q       <= '0;
            res1_q       <= '0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            vld0_q       <= 1'b0;
            vld1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res0_q       <= res0_d;
            res1_q       <= res1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            vld0_q       <= vld0_d;
            vld1_q       <= vld1_d;
        end
    end

    assign bus.rsp0_valid    = vld0_q;
    assign bus.rsp0_result   = res0_q;
    assign bus.rsp0_err      = err0_q;
    assign bus.rsp1_valid    = vld1_q;
    assign bus.rsp1_result   = res1_q;
    assign bus.rsp1_err      = err1_q;
    assign bus.alu_operation = op_q;
    assign bus.alu_srca      = a_q;
    assign bus.alu_srcb      = b_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter with a transaction-level
// reference model and a small behavioural ALU standing in for the real one.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arbiter_if bus ();

  alu_share_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- behavioural ALU ----------------
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h3: r = a - b;
      4'h4: r = a ^ b;
      4'h5: r = a + b;
      4'h8: r = {31'd0, a == b};
      4'h9: r = {31'd0, a != b};
      4'hA: r = {31'd0, $signed(a) < $signed(b)};
      4'hB: r = {31'd0, $signed(a) >= $signed(b)};
      4'hC: r = a >> b[4:0];
      4'hD: r = a << b[4:0];
      4'hE: r = {31'd0, $signed(a) < $signed(b)};
      default: r = a + b + 32'd1;
    endcase
    return r;
  endfunction

  always_comb bus.alu_result = alu_fn(bus.alu_operation, bus.alu_srca, bus.alu_srcb);

  function automatic logic is_sup(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, [4'h8:4'hE]};
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    return is_sup(op) ? alu_fn(op, a, b) : 32'd0;
  endfunction

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  cmd_t        q0[$];
  cmd_t        q1[$];
  logic        hs0 = 1'b0;
  logic        hs1 = 1'b0;
  int          rdy0_mode = 1;
  int          rdy1_mode = 1;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic        glog_port[$];
  int          glog_cyc[$];
  int          done_cnt = 0;

  logic        busy = 1'b0;
  logic        owner = 1'b0;
  logic        m_last = 1'b1;
  int          age = 0;
  cmd_t        cur;
  logic        exp_v, gv, g, own_rdy;

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one op in flight, response visible from the second edge
  // after the command transfer, gone after the edge where it is accepted.
  always @(negedge clk) begin
    hs0 = 1'b0;
    hs1 = 1'b0;
    if (busy) begin
      exp_v = (age >= 1);
      check1("req0_ready_busy", bus.req0_ready, 1'b0);
      check1("req1_ready_busy", bus.req1_ready, 1'b0);
      check1("rsp0_valid", bus.rsp0_valid, exp_v && !owner);
      check1("rsp1_valid", bus.rsp1_valid, exp_v && owner);
      if (!exp_v) begin
        check32("alu_operation", 32'(bus.alu_operation), 32'(cur.op));
        check32("alu_srca", bus.alu_srca, cur.a);
        check32("alu_srcb", bus.alu_srcb, cur.b);
      end else if (!owner) begin
        check32("rsp0_result", bus.rsp0_result, exp_q[0]);
        check1("rsp0_err", bus.rsp0_err, exp_err_q[0]);
      end else begin
        check32("rsp1_result", bus.rsp1_result, exp_q[0]);
        check1("rsp1_err", bus.rsp1_err, exp_err_q[0]);
      end
      own_rdy = owner ? bus.rsp1_ready : bus.rsp0_ready;
      if (reset) begin
        busy = 1'b0;
        exp_q.delete();
        exp_err_q.delete();
      end else if (exp_v && own_rdy) begin
        busy = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_err_q.pop_front());
        done_cnt++;
      end else if (!exp_v) begin
        age++;
      end
    end else begin
      check1("rsp0_valid_idle", bus.rsp0_valid, 1'b0);
      check1("rsp1_valid_idle", bus.rsp1_valid, 1'b0);
      if (reset) begin
        check1("req0_ready_rst", bus.req0_ready, 1'b0);
        check1("req1_ready_rst", bus.req1_ready, 1'b0);
      end else begin
        gv = bus.req0_valid || bus.req1_valid;
        g  = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
        check1("req0_ready", bus.req0_ready, gv && !g);
        check1("req1_ready", bus.req1_ready, gv && g);
        if (gv) begin
          cur    = g ? {bus.req1_op, bus.req1_a, bus.req1_b} : {bus.req0_op, bus.req0_a, bus.req0_b};
          busy   = 1'b1;
          owner  = g;
          m_last = g;
          age    = 0;
          exp_q.push_back(ref_result(cur.op, cur.a, cur.b));
          exp_err_q.push_back(!is_sup(cur.op));
          glog_port.push_back(g);
          glog_cyc.push_back(cyc);
          if (g) hs1 = 1'b1;
          else   hs0 = 1'b1;
        end
      end
    end
    if (reset) m_last = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (hs0 && q0.size() > 0) void'(q0.pop_front());
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin
      bus.req0_valid = 1'b1;
      bus.req0_op = q0[0].op; bus.req0_a = q0[0].a; bus.req0_b = q0[0].b;
    end else begin
      bus.req0_valid = 1'b0;
      bus.req0_op = 4'($urandom); bus.req0_a = $urandom; bus.req0_b = $urandom;
    end
    if (q1.size() > 0) begin
      bus.req1_valid = 1'b1;
      bus.req1_op = q1[0].op; bus.req1_a = q1[0].a; bus.req1_b = q1[0].b;
    end else begin
      bus.req1_valid = 1'b0;
      bus.req1_op = 4'($urandom); bus.req1_a = $urandom; bus.req1_b = $urandom;
    end
    bus.rsp0_ready = (rdy0_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy0_mode == 1);
    bus.rsp1_ready = (rdy1_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy1_mode == 1);
  endtask

  task automatic push_cmd(input logic p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    cmd_t c;
    c = {op, a, b};
    if (p) q1.push_back(c);
    else   q0.push_back(c);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && n < max_cycles) begin
      step();
      n++;
    end
    check1("drain_in_time", (q0.size() == 0 && q1.size() == 0 && !busy), 1'b1);
  endtask

  task automatic reset_state_checks();
    check1("rst_req0_ready", bus.req0_ready, 1'b0);
    check1("rst_req1_ready", bus.req1_ready, 1'b0);
    check1("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    check1("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
    check32("rst_rsp0_result", bus.rsp0_result, 32'd0);
    check32("rst_rsp1_result", bus.rsp1_result, 32'd0);
    check1("rst_rsp0_err", bus.rsp0_err, 1'b0);
    check1("rst_rsp1_err", bus.rsp1_err, 1'b0);
    check32("rst_alu_operation", 32'(bus.alu_operation), 32'd0);
    check32("rst_alu_srca", bus.alu_srca, 32'd0);
    check32("rst_alu_srcb", bus.alu_srcb, 32'd0);
    check32("rst_state", 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int done0;
    logic p;
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;

    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;

    // Reset state, then a single op presented while reset is still high.
    reset = 1'b1;
    repeat (3) step();
    reset_state_checks();
    push_cmd(1'b0, ALU_ADD, 32'd5, 32'd7);
    repeat (2) step();
    reset = 1'b0;
    glog_port.delete(); glog_cyc.delete();
    wait_drain(50);
    check32("t1_done", 32'(done_cnt), 32'd1);
    check1("t1_grant_port0", glog_port.size() > 0 ? glog_port[0] : 1'bx, 1'b0);

    // Contention right after reset: port 0 first, then port 1.
    do_reset(2);
    glog_port.delete(); glog_cyc.delete();
    push_cmd(1'b0, ALU_SUB, 32'd10, 32'd3);
    push_cmd(1'b1, ALU_XOR, 32'hF0, 32'hFF);
    wait_drain(50);
    check32("t2_grants", 32'(glog_port.size()), 32'd2);
    check1("t2_first", glog_port.size() > 1 ? glog_port[0] : 1'bx, 1'b0);
    check1("t2_second", glog_port.size() > 1 ? glog_port[1] : 1'bx, 1'b1);

    // Fairness: alternate grants, three cycles per op.
    glog_port.delete(); glog_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      push_cmd(1'b0, ALU_ADD, $urandom, $urandom);
      push_cmd(1'b1, ALU_AND, $urandom, $urandom);
    end
    wait_drain(100);
    check32("t3_grants", 32'(glog_port.size()), 32'd6);
    for (int i = 0; i < 6 && i < glog_port.size(); i++) begin
      check1("t3_alternate", glog_port[i], 1'(i % 2));
      if (i > 0) check32("t3_spacing", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd3);
    end

    // Backpressure on port 1 while port 0 waits.
    rdy1_mode = 0;
    push_cmd(1'b1, ALU_OR, 32'h1200, 32'h0034);
    n = 0;
    while (!bus.rsp1_valid && n < 20) begin step(); n++; end
    check1("t4_rsp1_seen", bus.rsp1_valid, 1'b1);
    glog_port.delete(); glog_cyc.delete();
    push_cmd(1'b0, ALU_ADD, 32'd100, 32'd23);
    repeat (5) step();
    check1("t4_req0_blocked", bus.req0_ready, 1'b0);
    check1("t4_rsp1_held", bus.rsp1_valid, 1'b1);
    check32("t4_rsp1_result", bus.rsp1_result, 32'h1234);
    rdy1_mode = 1;
    wait_drain(50);
    check32("t4_grants", 32'(glog_port.size()), 32'd1);
    check1("t4_port0_after", glog_port.size() > 0 ? glog_port[0] : 1'bx, 1'b0);

    // Unsupported opcode.
    rdy1_mode = 0;
    push_cmd(1'b1, 4'b0110, 32'd1, 32'd1);
    n = 0;
    while (!bus.rsp1_valid && n < 20) begin step(); n++; end
    check1("t5_rsp1_seen", bus.rsp1_valid, 1'b1);
    check32("t5_result", bus.rsp1_result, 32'd0);
    check1("t5_err", bus.rsp1_err, 1'b1);
    rdy1_mode = 1;
    wait_drain(50);

    // Reset during EXEC discards the op.
    glog_port.delete(); glog_cyc.delete();
    done0 = done_cnt;
    push_cmd(1'b0, ALU_SLL, 32'd1, 32'd4);
    n = 0;
    while (glog_port.size() == 0 && n < 20) begin step(); n++; end
    check32("t6_in_exec", 32'(dbg_state), 32'(EXEC));
    do_reset(2);
    reset_state_checks();
    repeat (5) step();
    check32("t6_no_response", 32'(done_cnt), 32'(done0));
    glog_port.delete(); glog_cyc.delete();
    push_cmd(1'b0, ALU_EQ, 32'd9, 32'd9);
    push_cmd(1'b1, ALU_NE, 32'd9, 32'd9);
    wait_drain(50);
    check1("t6_port0_wins", glog_port.size() > 0 ? glog_port[0] : 1'bx, 1'b0);

    // Random traffic with random response backpressure.
    rdy0_mode = 2;
    rdy1_mode = 2;
    done0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      p  = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      push_cmd(p, op, a, b);
      if ($urandom_range(0, 3) == 0) step();
    end
    wait_drain(3000);
    check32("t7_completed", 32'(done_cnt - done0), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
